// File: rtl/mode_text_pkg.sv
// Shared constants, encodings and label lookup for the mode banner streamer.
package mode_text_pkg;

  localparam logic [7:0] SP  = 8'h20;
  localparam logic [7:0] DOT = 8'h2E;
  localparam logic [7:0] CR  = 8'h0D;
  localparam logic [7:0] LF  = 8'h0A;

  localparam int LEN_STD  = 10;
  localparam int LEN_UART = 9;

  typedef enum logic [1:0] {
    MODE_CLOCK = 2'd0,
    MODE_ALARM = 2'd1,
    MODE_TIMER = 2'd2,
    MODE_UART  = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEND = 3'd1,
    ST_CR   = 3'd2,
    ST_LF   = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  function automatic int lbl_len(input logic [1:0] m);
    return (m == MODE_UART) ? LEN_UART : LEN_STD;
  endfunction

  // Labels are packed first-character-in-MSB; shift left to bring offset to the top byte.
  function automatic logic [7:0] lbl_char(input logic [1:0] m, input int off);
    logic [79:0] s;
    case (m)
      MODE_CLOCK: s = "CLOCK_MODE";
      MODE_ALARM: s = "ALARM_MODE";
      MODE_TIMER: s = "TIMER_MODE";
      default:    s = "UART_MODE ";
    endcase
    s = s << (8 * off);
    return s[79:72];
  endfunction

endpackage

// File: rtl/mode_text_rom.sv
// Combinational character generator: (mode, position, blink) -> line byte.
module mode_text_rom
  import mode_text_pkg::*;
#(
  parameter int LEAD_SP  = 3,
  parameter int BLINK_EN = 1,
  parameter int IDX_W    = 5
) (
  input  logic [1:0]       mode_i,
  input  logic [IDX_W-1:0] pos_i,
  input  logic             blink_i,
  output logic [7:0]       char_o
);

  int p;
  int l;

  always_comb begin
    p      = int'(pos_i);
    l      = lbl_len(mode_i);
    char_o = SP;
    if (p >= LEAD_SP && p < LEAD_SP + l)
      char_o = lbl_char(mode_i, p - LEAD_SP);
    else if (p == LEAD_SP + l)
      char_o = (BLINK_EN != 0 && blink_i) ? SP : DOT;
  end

endmodule

// File: rtl/mode_text_streamer.sv
// Streams one mode banner line over a valid/ready byte interface, with blinking dot
// and optional CR/LF terminator.
module mode_text_streamer
  import mode_text_pkg::*;
#(
  parameter int LINE_LEN  = 32,
  parameter int LEAD_SP   = 3,
  parameter int BLINK_EN  = 1,
  parameter int TERMINATE = 1,
  parameter int IDX_W     = $clog2(LINE_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_1s,
  input  logic [1:0]       mode_sel,
  input  logic             start,
  input  logic             tx_ready,
  output logic             tx_valid,
  output logic [7:0]       tx_data,
  output logic             busy,
  output logic             line_done,
  output logic [IDX_W-1:0] index
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(LINE_LEN - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [1:0]       mode_q, mode_d;
  logic             blat_q, blat_d;
  logic             blink_q;
  logic [7:0]       rom_char;
  logic             xfer;

  mode_text_rom #(
    .LEAD_SP (LEAD_SP),
    .BLINK_EN(BLINK_EN),
    .IDX_W   (IDX_W)
  ) u_rom (
    .mode_i (mode_q),
    .pos_i  (idx_q),
    .blink_i(blat_q),
    .char_o (rom_char)
  );

  assign tx_valid  = (state_q == ST_SEND) || (state_q == ST_CR) || (state_q == ST_LF);
  assign busy      = tx_valid;
  assign line_done = (state_q == ST_DONE);
  assign index     = idx_q;
  assign xfer      = tx_valid && tx_ready;

  always_comb begin
    case (state_q)
      ST_SEND: tx_data = rom_char;
      ST_CR:   tx_data = CR;
      ST_LF:   tx_data = LF;
      default: tx_data = 8'h00;
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mode_d  = mode_q;
    blat_d  = blat_q;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_SEND;
        idx_d   = '0;
        mode_d  = mode_sel;
        blat_d  = blink_q;
      end
      ST_SEND: if (xfer) begin
        // Index is cleared on the last byte so it reads 0 during the terminator.
        if (idx_q == LAST) begin
          idx_d   = '0;
          state_d = (TERMINATE != 0) ? ST_CR : ST_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_CR:   if (xfer) state_d = ST_LF;
      ST_LF:   if (xfer) state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      mode_q  <= '0;
      blat_q  <= 1'b0;
      blink_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
      blat_q  <= blat_d;
      if (tick_1s) blink_q <= ~blink_q;
    end
  end

endmodule

// File: tb/tb_mode_text_streamer.sv
// Scoreboard bench for mode_text_streamer: default-parameter DUT plus a short,
// unterminated variant.
module tb_mode_text_streamer;

  typedef struct {
    logic [7:0] data;
    logic [4:0] idx;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick_1s = 1'b0;
  logic [1:0] mode_sel = 2'd3;
  logic       start = 1'b0;
  logic       tx_ready;
  logic       tx_valid, busy, line_done;
  logic [7:0] tx_data;
  logic [4:0] index;

  logic       s_start = 1'b0;
  logic       s_tick = 1'b0;
  logic       s_ready = 1'b1;
  logic [1:0] s_mode = 2'd1;
  logic       s_valid, s_busy, s_done;
  logic [7:0] s_data;
  logic [3:0] s_index;

  mode_text_streamer dut (
    .clk(clk), .rst(rst), .tick_1s(tick_1s), .mode_sel(mode_sel), .start(start),
    .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data), .busy(busy),
    .line_done(line_done), .index(index)
  );

  mode_text_streamer #(.LINE_LEN(16), .LEAD_SP(8), .TERMINATE(0)) dut_s (
    .clk(clk), .rst(rst), .tick_1s(s_tick), .mode_sel(s_mode), .start(s_start),
    .tx_ready(s_ready), .tx_valid(s_valid), .tx_data(s_data), .busy(s_busy),
    .line_done(s_done), .index(s_index)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   done_cyc = -1;
  int   last_xfer_cyc = -1;
  bit   tb_blink = 1'b0;
  bit   bp_en = 1'b0;
  exp_t exp_q[$];
  exp_t exp2_q[$];

  bit         stall_q = 1'b0;
  logic [7:0] stall_data;
  logic [4:0] stall_idx;

  always @(posedge clk) begin
    #1;
    tx_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Reference line builder, written from the character rules, not the RTL.
  task automatic push_line(input int mode, input bit blk, input int len, input int lead,
                           input bit term, input bit sel);
    string lbl;
    exp_t  e;
    case (mode)
      0: lbl = "CLOCK_MODE";
      1: lbl = "ALARM_MODE";
      2: lbl = "TIMER_MODE";
      default: lbl = "UART_MODE";
    endcase
    for (int p = 0; p < len; p++) begin
      e.idx = 5'(p);
      if (p >= lead && p - lead < lbl.len()) e.data = lbl[p - lead];
      else if (p == lead + lbl.len()) e.data = blk ? 8'h20 : 8'h2E;
      else e.data = 8'h20;
      if (sel) exp2_q.push_back(e); else exp_q.push_back(e);
    end
    if (term) begin
      e.idx = 5'd0; e.data = 8'h0D; exp_q.push_back(e);
      e.data = 8'h0A; exp_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      if (line_done) done_cyc = cyc;
      if (stall_q) begin
        n_cmp++;
        if (!tx_valid || tx_data !== stall_data || index !== stall_idx) begin
          n_err++;
          $display("FAIL stall_hold: valid=%b data=%h idx=%0d, required valid=1 data=%h idx=%0d",
                   tx_valid, tx_data, index, stall_data, stall_idx);
        end
      end
      if (tx_valid && tx_ready) begin
        n_cmp++;
        last_xfer_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL sb_extra: got byte %h idx %0d, required no transfer", tx_data, index);
        end else begin
          e = exp_q.pop_front();
          if (tx_data !== e.data || index !== e.idx) begin
            n_err++;
            $display("FAIL sb_byte: got %h idx %0d, required %h idx %0d", tx_data, index, e.data, e.idx);
          end
        end
      end
      stall_q    = tx_valid && !tx_ready;
      stall_data = tx_data;
      stall_idx  = index;
    end else begin
      stall_q = 1'b0;
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic pulse_tick();
    tick_1s = 1'b1;
    @(posedge clk); #1;
    tick_1s = 1'b0;
    tb_blink = ~tb_blink;
  endtask

  task automatic wait_line(input int budget, output int busy_cyc, output int done_cnt,
                           output int post_busy, output bit to);
    int after;
    after = -1; busy_cyc = 0; done_cnt = 0; post_busy = 0; to = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (after < 0) busy_cyc += int'(busy);
      else post_busy += int'(busy | tx_valid);
      if (line_done) done_cnt++;
      if (after < 0 && line_done) after = 0;
      else if (after >= 0) after++;
      if (after == 4) begin to = 1'b0; break; end
    end
  endtask

  task automatic check_line_end(input string tag, input int busy_exp, input int busy_cyc,
                                input int done_cnt, input int post_busy, input bit to);
    n_cmp++;
    if (to || done_cnt != 1 || post_busy != 0 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_end: timeout=%0d done=%0d post_busy=%0d left=%0d, required 0/1/0/0",
               tag, to, done_cnt, post_busy, exp_q.size());
    end
    if (busy_exp > 0) begin
      n_cmp++;
      if (busy_cyc != busy_exp) begin
        n_err++;
        $display("FAIL %s_busy: %0d cycles, required %0d", tag, busy_cyc, busy_exp);
      end
    end
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0 || line_done !== 1'b0 || index !== 5'd0) begin
      n_err++;
      $display("FAIL reset_state: v=%b d=%h b=%b ld=%b i=%0d, required all 0", tx_valid, tx_data, busy, line_done, index);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int bc, dc, pb; bit to;
    mode_sel = 2'd3;
    push_line(3, tb_blink, 32, 3, 1'b1, 1'b0);
    pulse_start();
    wait_line(200, bc, dc, pb, to);
    check_line_end("basic", 34, bc, dc, pb, to);
    n_cmp++;
    if (done_cyc != last_xfer_cyc + 1) begin
      n_err++;
      $display("FAIL basic_done_lat: done at %0d, required %0d", done_cyc, last_xfer_cyc + 1);
    end
  endtask

  task automatic test_blink();
    int bc, dc, pb; bit to;
    pulse_tick();
    mode_sel = 2'd0;
    push_line(0, tb_blink, 32, 3, 1'b1, 1'b0);
    pulse_start();
    wait_line(200, bc, dc, pb, to);
    check_line_end("blink_on", 34, bc, dc, pb, to);
    pulse_tick();
    push_line(0, tb_blink, 32, 3, 1'b1, 1'b0);
    pulse_start();
    wait_line(200, bc, dc, pb, to);
    check_line_end("blink_off", 34, bc, dc, pb, to);
  endtask

  task automatic test_back_pressure();
    int bc, dc, pb; bit to;
    mode_sel = 2'd3;
    bp_en = 1'b1;
    push_line(3, tb_blink, 32, 3, 1'b1, 1'b0);
    pulse_start();
    wait_line(1000, bc, dc, pb, to);
    bp_en = 1'b0;
    check_line_end("bp", 0, bc, dc, pb, to);
  endtask

  task automatic test_midline();
    int bc, dc, pb; bit to, hit;
    mode_sel = 2'd3;
    push_line(3, tb_blink, 32, 3, 1'b1, 1'b0);
    pulse_start();
    hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      @(negedge clk);
      if (busy && index == 5'd5) hit = 1'b1;
    end
    n_cmp++;
    if (!hit) begin n_err++; $display("FAIL midline_reach: index 5 not seen, required seen"); end
    mode_sel = 2'd0;
    tick_1s = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    tick_1s = 1'b0;
    start = 1'b0;
    tb_blink = ~tb_blink;
    wait_line(200, bc, dc, pb, to);
    check_line_end("midline", 0, bc, dc, pb, to);
  endtask

  task automatic test_reset_midline();
    int bc, dc, pb; bit to, hit;
    mode_sel = 2'd3;
    push_line(3, tb_blink, 32, 3, 1'b1, 1'b0);
    pulse_start();
    hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      @(negedge clk);
      if (busy && index == 5'd8) hit = 1'b1;
    end
    #1 rst = 1'b0;
    #1;
    n_cmp++;
    if (!hit || tx_valid !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0 || index !== 5'd0) begin
      n_err++;
      $display("FAIL rst_mid: hit=%0d v=%b d=%h b=%b i=%0d, required hit=1 and all 0", hit, tx_valid, tx_data, busy, index);
    end
    exp_q.delete();
    tb_blink = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (busy !== 1'b0 || tx_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rst_idle: busy=%b valid=%b, required 0/0", busy, tx_valid);
    end
    push_line(3, tb_blink, 32, 3, 1'b1, 1'b0);
    pulse_start();
    wait_line(200, bc, dc, pb, to);
    check_line_end("rst_relaunch", 34, bc, dc, pb, to);
  endtask

  task automatic test_short_line();
    exp_t e;
    int nbytes, ndone, last;
    nbytes = 0; ndone = 0; last = -10;
    push_line(1, 1'b0, 16, 8, 1'b0, 1'b1);
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (s_valid) begin
        n_cmp++;
        nbytes++;
        last = i;
        if (exp2_q.size() == 0) begin
          n_err++;
          $display("FAIL short_extra: got %h idx %0d, required no byte", s_data, s_index);
        end else begin
          e = exp2_q.pop_front();
          if (s_data !== e.data || s_index !== e.idx[3:0]) begin
            n_err++;
            $display("FAIL short_byte: got %h idx %0d, required %h idx %0d", s_data, s_index, e.data, e.idx);
          end
        end
      end
      if (s_done) begin
        n_cmp++;
        ndone++;
        if (i != last + 1) begin
          n_err++;
          $display("FAIL short_done_lat: done at %0d, required %0d", i, last + 1);
        end
      end
    end
    n_cmp++;
    if (nbytes != 16 || ndone != 1 || exp2_q.size() != 0) begin
      n_err++;
      $display("FAIL short_count: bytes=%0d done=%0d left=%0d, required 16/1/0", nbytes, ndone, exp2_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_blink();
    test_back_pressure();
    test_midline();
    test_reset_midline();
    test_short_line();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mode_text_streamer.md
Name: mode_text_streamer

Overview:
Parametrised generator for the on-screen mode banner. It renders one text line for the selected clock mode and streams it byte-by-byte to the UART transmitter over a valid/ready handshake. The trailing '.' blinks at the 1 s rate, and an optional CR/LF terminator ends each line. It sits between the mode controller and uart_tx, and replaces the fixed 32-entry per-mode character tables.

Parameters:
- LINE_LEN, 32, characters per line before the terminator (range 16..64).
- LEAD_SP, 3, number of leading spaces before the label.
- BLINK_EN, 1, 1 = the dot after the label blinks; 0 = the dot is always shown.
- TERMINATE, 1, 1 = append 8'h0D then 8'h0A after the line; 0 = no terminator.
- IDX_W, $clog2(LINE_LEN), width of the index output.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- tick_1s  in  1  one-cycle pulse in the clk domain, once per second.
- mode_sel  in  2  0=CLOCK_MODE, 1=ALARM_MODE, 2=TIMER_MODE, 3=UART_MODE.
- start  in  1  request to emit one line; level-sampled in IDLE only.
- tx_ready  in  1  UART transmitter can accept a byte.
- tx_valid  out  1  tx_data is valid.
- tx_data  out  8  ASCII byte.
- busy  out  1  high from start acceptance until the line completes.
- line_done  out  1  one-cycle pulse after the last byte is accepted.
- index  out  IDX_W  position of the byte currently presented (0 during the terminator).

Behaviour:
- Reset (rst=0, async): state=IDLE; tx_valid=0, tx_data=8'h00, busy=0, line_done=0, index=0, blink=0. Applies immediately mid-line; the partial line is abandoned and nothing resumes.
- Blink register: toggles on every tick_1s, including while busy.
- Line content at position p, with L = label length:
  - p < LEAD_SP: 8'h20 (space).
  - LEAD_SP <= p < LEAD_SP+L: label ASCII. Labels are "CLOCK_MODE", "ALARM_MODE", "TIMER_MODE" (L=10) and "UART_MODE" (L=9).
  - p = LEAD_SP+L: 8'h2E ('.'), or 8'h20 when BLINK_EN=1 and the latched blink=1.
  - Beyond that: 8'h20.
  - A label that would exceed LINE_LEN is truncated at LINE_LEN-1.
- FSM states: IDLE, SEND, CR, LF, DONE.
  - IDLE: on start=1, latch mode_sel and blink and set index=0. At the next cycle, busy=1, tx_valid=1, and tx_data holds char 0 (latency 1 cycle).
  - SEND: a transfer occurs when tx_valid && tx_ready. tx_data and index stay stable until the transfer.
    - After a transfer at index < LINE_LEN-1, the next char is presented in the following cycle with no bubble.
    - After a transfer at index LINE_LEN-1, go to CR if TERMINATE=1, else to DONE.
  - CR: present 8'h0D and hold it until transfer, then go to LF.
  - LF: present 8'h0A and hold it until transfer, then go to DONE.
  - DONE: tx_valid=0, line_done=1 for exactly one cycle, busy=0, then IDLE. start is not accepted in DONE, so the minimum gap between lines is 1 idle cycle.
- Changes to mode_sel and tick_1s during a line do not alter the bytes of that line; the latched copies are used throughout. A start pulse while busy is ignored; it is neither queued nor counted.
- tx_valid never drops without a transfer, except on reset.
- Index counter wraps: when LINE_LEN is not a power of 2, it stops at LINE_LEN-1 and never aliases.

Decomposition:
- Package mode_text_pkg holds:
  - ASCII constants: SP=8'h20, DOT=8'h2E, CR=8'h0D, LF=8'h0A.
  - Mode encodings.
  - The FSM state enum.
  - Label lengths.
  - A label-character function (mode, offset) -> byte.
- One combinational sub-module, mode_text_rom (inputs mode, position, blink; output byte), instantiated once. The top holds the FSM, counters and output registers.

Test Plan:
- Defaults, mode_sel=3, blink=0, tx_ready tied 1, pulse start → 34 bytes on consecutive cycles: "   UART_MODE." followed by 19×8'h20, then 8'h0D, 8'h0A. Byte 12 = 8'h2E, line_done pulses 1 cycle after the LF, busy is high for 34 cycles.
- Mode 0 after one tick_1s (blink=1) → bytes 3..12 = "CLOCK_MODE", byte 13 = 8'h20. Repeat after a second tick → byte 13 = 8'h2E.
- Random tx_ready backpressure (~50 % low) → tx_data and index stay stable while tx_valid && !tx_ready. The byte sequence is identical to the first scenario and no byte is dropped or duplicated.
- mode_sel 3→0 and tick_1s at byte 5 of a line, plus start re-pulsed while busy → line content unchanged. Exactly one line_done, and no second line starts.
- rst asserted at byte 8 → outputs go to 0 asynchronously within the same cycle and state=IDLE. A new start after release emits the full line from index 0 with blink=0.
- LINE_LEN=16, TERMINATE=0, LEAD_SP=8, mode 1 → bytes 8..15 = "ALARM_MO" (truncated), no dot, no CR/LF, line_done after byte 15.
